updown_counter_param: RTL and testbench

//  Parametrised synchronous up/down counter: successor to the fixed 3-bit up/down counter.

---
 rtl/updown_counter_param_if.sv | 27 ++
 rtl/updown_counter_param.sv | 90 +++++++++
 tb/tb_updown_counter_param.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/updown_counter_param_if.sv
// Control and status bundle for updown_counter_param.
// The master drives the count controls and the slave (the counter) returns count and flags.
interface updown_counter_param_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic             up;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             clr;
   logic [WIDTH-1:0] q;
   logic             at_max;
   logic             at_min;
   logic             wrap;
   logic             ovf;
   logic             unf;

   modport master (
      output en, up, load, load_val, clr,
      input  q, at_max, at_min, wrap, ovf, unf
   );

   modport slave (
      input  en, up, load, load_val, clr,
      output q, at_max, at_min, wrap, ovf, unf
   );
endinterface

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter over 0..MAX_VAL with wrap or saturate, load, clear
// and boundary flags. Edge priority is clr > load > en.
module updown_counter_param #(
   parameter int WIDTH     = 4,
   parameter int MAX_VAL   = 9,
   parameter int STEP      = 1,
   parameter int SATURATE  = 0,
   parameter int RESET_VAL = 0
) (
   input logic                   clk,
   input logic                   rst,
   updown_counter_param_if.slave bus
);
   localparam int W1 = WIDTH + 1;
   localparam logic [W1-1:0]    MAX_W   = W1'(MAX_VAL);
   localparam logic [W1-1:0]    MOD_W   = W1'(MAX_VAL + 1);
   localparam logic [W1-1:0]    STEP_W  = W1'(STEP);
   localparam logic [WIDTH-1:0] RESET_Q = WIDTH'(RESET_VAL);
   localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MAX_VAL);

   logic [WIDTH-1:0] q_r, q_nxt;
   logic             wrap_r, wrap_nxt;
   logic             ovf_r, ovf_nxt;
   logic             unf_r, unf_nxt;

   // One extra bit of headroom so q+STEP and q+MOD-STEP never truncate.
   logic [W1-1:0] q_ext, sum_up, sum_dn_wrap, load_ext;

   always_comb begin
      q_ext       = {1'b0, q_r};
      sum_up      = q_ext + STEP_W;
      sum_dn_wrap = q_ext + MOD_W - STEP_W;
      load_ext    = {1'b0, bus.load_val};
   end

   always_comb begin
      q_nxt    = q_r;
      wrap_nxt = 1'b0;
      ovf_nxt  = ovf_r;
      unf_nxt  = unf_r;
      if (bus.clr) begin
         q_nxt   = RESET_Q;
         ovf_nxt = 1'b0;
         unf_nxt = 1'b0;
      end else if (bus.load) begin
         q_nxt = (load_ext > MAX_W) ? MAX_Q : bus.load_val;
      end else if (bus.en) begin
         if (bus.up) begin
            if (sum_up <= MAX_W) begin
               q_nxt = sum_up[WIDTH-1:0];
            end else begin
               wrap_nxt = 1'b1;
               ovf_nxt  = 1'b1;
               if (SATURATE != 0) q_nxt = MAX_Q;
               else               q_nxt = W1'(sum_up - MOD_W);
            end
         end else begin
            if (q_ext >= STEP_W) begin
               q_nxt = W1'(q_ext - STEP_W);
            end else begin
               wrap_nxt = 1'b1;
               unf_nxt  = 1'b1;
               if (SATURATE != 0) q_nxt = '0;
               else               q_nxt = sum_dn_wrap[WIDTH-1:0];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_r    <= RESET_Q;
         wrap_r <= 1'b0;
         ovf_r  <= 1'b0;
         unf_r  <= 1'b0;
      end else begin
         q_r    <= q_nxt;
         wrap_r <= wrap_nxt;
         ovf_r  <= ovf_nxt;
         unf_r  <= unf_nxt;
      end
   end

   assign bus.q      = q_r;
   assign bus.at_max = (q_r == MAX_Q);
   assign bus.at_min = (q_r == '0);
   assign bus.wrap   = wrap_r;
   assign bus.ovf    = ovf_r;
   assign bus.unf    = unf_r;
endmodule

// File: tb/tb_updown_counter_param.sv
// Directed bench: default counter driven from a vector table, plus hand sequences for
// async reset, saturate mode with STEP=3 and wrap mode with STEP=4.
module tb_updown_counter_param;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   updown_counter_param_if #(.WIDTH(4)) b0 ();
   updown_counter_param_if #(.WIDTH(4)) b1 ();
   updown_counter_param_if #(.WIDTH(4)) b2 ();

   updown_counter_param u0 (.clk(clk), .rst(rst), .bus(b0));
   updown_counter_param #(.STEP(3), .SATURATE(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
   updown_counter_param #(.STEP(4)) u2 (.clk(clk), .rst(rst), .bus(b2));

   typedef struct {
      logic       en, up, load, clr;
      logic [3:0] lv;
      logic [3:0] q;
      logic       wrap, ovf, unf;
   } vec_t;

   vec_t vec_q[$];
   int   checks   = 0;
   int   failures = 0;

   // {q, wrap, ovf, unf, at_max, at_min}; all instances use MAX_VAL=9
   function automatic logic [8:0] pack(input logic [3:0] q, input logic w, input logic o, input logic u);
      return {q, w, o, u, (q == 4'd9), (q == 4'd0)};
   endfunction

   function automatic logic [8:0] outs(input int which);
      case (which)
         0:       return {b0.q, b0.wrap, b0.ovf, b0.unf, b0.at_max, b0.at_min};
         1:       return {b1.q, b1.wrap, b1.ovf, b1.unf, b1.at_max, b1.at_min};
         default: return {b2.q, b2.wrap, b2.ovf, b2.unf, b2.at_max, b2.at_min};
      endcase
   endfunction

   task automatic drive(input int which, input logic en, input logic up, input logic load,
                        input logic clr, input logic [3:0] lv);
      case (which)
         0: begin b0.en = en; b0.up = up; b0.load = load; b0.clr = clr; b0.load_val = lv; end
         1: begin b1.en = en; b1.up = up; b1.load = load; b1.clr = clr; b1.load_val = lv; end
         default: begin b2.en = en; b2.up = up; b2.load = load; b2.clr = clr; b2.load_val = lv; end
      endcase
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got q=%0d wrap=%b ovf=%b unf=%b max=%b min=%b, expected q=%0d wrap=%b ovf=%b unf=%b max=%b min=%b",
                  name, act[8:5], act[4], act[3], act[2], act[1], act[0],
                  exp[8:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
      end
   endtask

   task automatic add(input logic en, input logic up, input logic load, input logic clr,
                      input logic [3:0] lv, input logic [3:0] q, input logic w,
                      input logic o, input logic u);
      vec_t v;
      v.en = en; v.up = up; v.load = load; v.clr = clr; v.lv = lv;
      v.q = q; v.wrap = w; v.ovf = o; v.unf = u;
      vec_q.push_back(v);
   endtask

   initial begin
      // 12 up-counts from 0: wrap only on 9->0, ovf sticky afterwards
      for (int k = 1; k <= 9; k++) add(1, 1, 0, 0, 0, 4'(k), 0, 0, 0);
      add(1, 1, 0, 0, 0, 0, 1, 1, 0);
      add(1, 1, 0, 0, 0, 1, 0, 1, 0);
      add(1, 1, 0, 0, 0, 2, 0, 1, 0);
      add(0, 1, 0, 0, 0, 2, 0, 1, 0);   // en=0 holds
      add(0, 0, 1, 0, 3, 3, 0, 1, 0);   // load keeps ovf
      add(0, 0, 0, 1, 0, 0, 0, 0, 0);   // clr
      add(1, 0, 0, 0, 0, 9, 1, 0, 1);   // down from 0 wraps
      add(1, 0, 0, 0, 0, 8, 0, 0, 1);
      add(1, 1, 1, 1, 5, 0, 0, 0, 0);   // clr beats load and en
      add(1, 1, 1, 0, 14, 9, 0, 0, 0);  // load clamps, no count
      add(1, 1, 0, 0, 0, 0, 1, 1, 0);
      add(0, 0, 1, 0, 5, 5, 0, 1, 0);
      add(1, 0, 0, 0, 0, 4, 0, 1, 0);
      add(1, 1, 0, 0, 0, 5, 0, 1, 0);   // direction change, no penalty
      add(0, 0, 1, 1, 7, 0, 0, 0, 0);   // load+clr -> RESET_VAL

      rst = 1'b0;
      for (int w = 0; w < 3; w++) drive(w, 0, 0, 0, 0, 0);
      step();
      step();
      check("reset_state", outs(0), pack(0, 0, 0, 0));
      rst = 1'b1;

      drive(0, 1, 1, 0, 0, 0);
      repeat (6) step();
      check("count_to_6", outs(0), pack(6, 0, 0, 0));
      #2 rst = 1'b0;
      #1 check("async_reset", outs(0), pack(0, 0, 0, 0));
      @(negedge clk);
      check("reset_held", outs(0), pack(0, 0, 0, 0));
      drive(0, 0, 1, 0, 0, 0);
      rst = 1'b1;
      step();
      check("release_hold", outs(0), pack(0, 0, 0, 0));

      for (int i = 0; i < vec_q.size(); i++) begin
         drive(0, vec_q[i].en, vec_q[i].up, vec_q[i].load, vec_q[i].clr, vec_q[i].lv);
         step();
         check($sformatf("vec%0d", i), outs(0),
               pack(vec_q[i].q, vec_q[i].wrap, vec_q[i].ovf, vec_q[i].unf));
      end
      drive(0, 0, 0, 0, 0, 0);

      // Saturate, STEP=3
      drive(1, 0, 0, 1, 0, 7); step(); check("sat_load7", outs(1), pack(7, 0, 0, 0));
      drive(1, 1, 1, 0, 0, 0); step(); check("sat_up_clamp", outs(1), pack(9, 1, 1, 0));
      step(); check("sat_up_at_max", outs(1), pack(9, 1, 1, 0));
      drive(1, 0, 0, 1, 0, 2); step(); check("sat_load2", outs(1), pack(2, 0, 1, 0));
      drive(1, 1, 0, 0, 0, 0); step(); check("sat_dn_clamp", outs(1), pack(0, 1, 1, 1));
      drive(1, 0, 0, 0, 0, 0); step(); check("sat_idle", outs(1), pack(0, 0, 1, 1));

      // Wrap, STEP=4
      drive(2, 0, 0, 1, 0, 8); step(); check("w4_load8", outs(2), pack(8, 0, 0, 0));
      drive(2, 1, 1, 0, 0, 0); step(); check("w4_up_wrap", outs(2), pack(2, 1, 1, 0));
      drive(2, 0, 0, 1, 0, 1); step(); check("w4_load1", outs(2), pack(1, 0, 1, 0));
      drive(2, 1, 0, 0, 0, 0); step(); check("w4_dn_wrap", outs(2), pack(7, 1, 1, 1));
      drive(2, 0, 0, 1, 0, 4); step(); check("w4_load4", outs(2), pack(4, 0, 1, 1));
      for (int k = 0; k < 4; k++) begin
         drive(2, 1, (k % 2) == 0, 0, 0, 0);
         step();
         check($sformatf("w4_alt%0d", k), outs(2), pack(((k % 2) == 0) ? 4'd8 : 4'd4, 0, 1, 1));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
